// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says button path.
package simon_pkg;

  localparam int unsigned NUM_BUTTONS = 4;

  typedef logic [1:0] btn_id_t;

  typedef enum logic [1:0] {
    StIdle,
    StHeld,
    StChord
  } btn_state_e;

  function automatic logic [2:0] popcount4(input logic [NUM_BUTTONS-1:0] b);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      n = n + {2'b00, b[i]};
    end
    return n;
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic btn_id_t onehot_to_id(input logic [NUM_BUTTONS-1:0] b);
    btn_id_t id;
    id = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (b[i]) id = btn_id_t'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/simon_event_fifo.sv
// Show-ahead synchronous FIFO of button IDs with flush and occupancy count.
module simon_event_fifo
  import simon_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  btn_id_t         data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic            valid_o,
  output btn_id_t         data_o,
  output logic            full_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  btn_id_t         mem_q [Depth];
  btn_id_t         mem_d [Depth];
  btn_id_t         last_q, last_d;
  logic            pop_ok, push_ok;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  // Hold the last presented head once the queue runs dry.
  assign data_o  = valid_o ? mem_q[rptr_q] : last_q;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    last_d  = data_o;
    pop_ok  = pop_i && valid_o;
    push_ok = push_i && (!full_o || pop_ok);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = data_i;
        wptr_d        = wptr_q + PtrW'(1);
      end
      if (pop_ok) rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      last_q  <= last_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/simon_button_capture.sv
// Turns debounced button levels into single-button press events, rejecting chords,
// and queues them for the game FSM over valid/ready.
module simon_button_capture #(
  parameter int unsigned NUM_BUTTONS = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic [NUM_BUTTONS-1:0]       i_Buttons,
  input  logic                         i_Enable,
  input  logic                         i_Flush,
  input  logic                         i_Clear_Ovf,
  input  logic                         i_Btn_Ready,
  output logic                         o_Btn_Valid,
  output logic [1:0]                   o_Btn_Id,
  output logic                         o_Any_Held,
  output logic                         o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]  o_Count
);
  import simon_pkg::*;

  btn_state_e             state_q, state_d;
  btn_id_t                held_q, held_d;
  logic                   ovf_q, ovf_d;
  logic                   push_req, pop, fifo_full;
  logic [NUM_BUTTONS-1:0] held_mask;

  assign held_mask  = NUM_BUTTONS'(1) << held_q;
  assign pop        = o_Btn_Valid && i_Btn_Ready;
  assign o_Any_Held = (state_q != StIdle);
  assign o_Overflow = ovf_q;

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    push_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_Buttons != '0) begin
          if (popcount4(i_Buttons) == 3'd1) begin
            state_d  = StHeld;
            held_d   = onehot_to_id(i_Buttons);
            // FSM tracks levels regardless, so a press begun during playback never fires.
            push_req = i_Enable;
          end else begin
            state_d = StChord;
          end
        end
      end
      StHeld: begin
        if (i_Buttons == '0) state_d = StIdle;
        else if ((i_Buttons & ~held_mask) != '0) state_d = StChord;
      end
      StChord: begin
        if (i_Buttons == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (i_Clear_Ovf) ovf_d = 1'b0;
    if (push_req && fifo_full && !pop && !i_Flush) ovf_d = 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= StIdle;
      held_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      ovf_q   <= ovf_d;
    end
  end

  simon_event_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clk),
    .rst_i   (i_Rst),
    .push_i  (push_req),
    .data_i  (held_d),
    .pop_i   (pop),
    .flush_i (i_Flush),
    .valid_o (o_Btn_Valid),
    .data_o  (o_Btn_Id),
    .full_o  (fifo_full),
    .count_o (o_Count)
  );

endmodule

// File: tb/tb_simon_button_capture.sv
// Directed plus randomized bench for simon_button_capture against a gesture-level queue model.
module tb_simon_button_capture;

  logic       clk = 1'b0;
  logic       rst, en, flush, clr, rdy;
  logic [3:0] btn;
  logic       valid, held, ovf;
  logic [1:0] id;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  // Model: an event fires on the first non-zero sample after an all-released
  // sample (or reset) when exactly one button shows and capture is enabled.
  int q[$];
  bit ovf_m;
  bit released_m;

  simon_button_capture #(
    .NUM_BUTTONS (4),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Buttons   (btn),
    .i_Enable    (en),
    .i_Flush     (flush),
    .i_Clear_Ovf (clr),
    .i_Btn_Ready (rdy),
    .o_Btn_Valid (valid),
    .o_Btn_Id    (id),
    .o_Any_Held  (held),
    .o_Overflow  (ovf),
    .o_Count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit do_pop, do_push;
    do_pop  = (q.size() > 0) && rdy;
    do_push = released_m && ($countones(btn) == 1) && en;
    if (rst) begin
      q.delete();
      ovf_m      = 1'b0;
      released_m = 1'b1;
    end else begin
      if (clr) ovf_m = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          if (q.size() < 4) q.push_back(onehot_idx(btn));
          else ovf_m = 1'b1;
        end
      end
      released_m = (btn == 4'b0000);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", int'(valid), int'(q.size() > 0));
    chk("count", int'(count), q.size());
    chk("overflow", int'(ovf), int'(ovf_m));
    chk("any_held", int'(held), int'(!released_m));
    if (q.size() > 0) chk("head_id", int'(id), q[0]);
    rst   = 1'b0;
    flush = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int idx);
    btn = 4'b0001 << idx;
    tick();
    btn = 4'b0000;
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; clr = 1'b0; rdy = 1'b0; btn = 4'b0000;
    tick();
    chk("reset_id", int'(id), 0);

    // Single press, held for 5 cycles.
    en = 1'b1;
    btn = 4'b0100;
    tick();
    chk("single_id", int'(id), 2);
    chk("single_valid", int'(valid), 1);
    run(4);
    chk("single_held", int'(held), 1);
    btn = 4'b0000;
    tick();
    chk("single_released", int'(held), 0);
    chk("single_count", int'(count), 1);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;

    // Chords.
    btn = 4'b0011; run(3);
    btn = 4'b0000; tick();
    chk("chord_none", int'(count), 0);
    btn = 4'b0001; tick();
    btn = 4'b1001; tick();
    btn = 4'b0000; tick();
    chk("chord_late_count", int'(count), 1);
    chk("chord_late_id", int'(id), 0);
    rdy = 1'b1; tick(); rdy = 1'b0;

    // Press begun while disabled never fires.
    en = 1'b0; btn = 4'b1000; run(2);
    en = 1'b1; run(2);
    btn = 4'b0000; tick();
    chk("disabled_count", int'(count), 0);

    // Overflow, in-order drain, then clear.
    press(0); press(1); press(2); press(3); press(0);
    chk("ovf_count", int'(count), 4);
    chk("ovf_flag", int'(ovf), 1);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", int'(id), i);
      tick();
    end
    rdy = 1'b0;
    clr = 1'b1; tick();
    chk("ovf_cleared", int'(ovf), 0);

    // Full FIFO with press coinciding with a pop.
    press(0); press(2); press(3); press(0);
    btn = 4'b0010; rdy = 1'b1; tick();
    rdy = 1'b0; btn = 4'b0000; tick();
    chk("fullpop_count", int'(count), 4);
    chk("fullpop_ovf", int'(ovf), 0);
    rdy = 1'b1; run(3);
    chk("fullpop_last", int'(id), 1);
    tick(); rdy = 1'b0;

    // Reset with button 3 held through it.
    press(1); press(2);
    btn = 4'b1000; rst = 1'b1; tick();
    chk("rst_count", int'(count), 0);
    tick();
    chk("rst_new_id", int'(id), 3);
    chk("rst_new_count", int'(count), 1);
    btn = 4'b0000; tick();

    // Flush with 3 queued (one already present plus two more).
    press(2); press(1);
    chk("pre_flush_count", int'(count), 3);
    flush = 1'b1; tick();
    chk("flush_valid", int'(valid), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 20) btn = 4'b0000;
      else if (r < 35) btn = 4'b0001 << $urandom_range(0, 3);
      else if (r < 42) btn = 4'($urandom);
      rdy   = ($urandom_range(0, 99) < 40);
      en    = ($urandom_range(0, 99) < 90);
      flush = ($urandom_range(0, 99) < 2);
      clr   = ($urandom_range(0, 99) < 3);
      rst   = ($urandom_range(0, 199) < 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
